// File: rtl/excp_csr_unit.sv
// Exception/interrupt CSR block: CSR storage, exception/ertn state updates, fetch redirect.
// Optional timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) is built only when EXCP_CSR_TIMER_EN is defined.
module excp_csr_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [5:0]  csr_ecode,
    input  logic [8:0]  csr_esubcode,
    input  logic [31:0] csr_era,
    input  logic        va_error,
    input  logic [31:0] bad_va,
    input  logic        excp_tlbrefill,
    input  logic [7:0]  hw_int_i,
    input  logic        csr_we,
    input  logic [13:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [13:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        int_pending,
    output logic [1:0]  crmd_plv,
    output logic        crmd_da
);
    localparam logic [13:0] CSR_CRMD      = 14'h000;
    localparam logic [13:0] CSR_PRMD      = 14'h001;
    localparam logic [13:0] CSR_ECFG      = 14'h004;
    localparam logic [13:0] CSR_ESTAT     = 14'h005;
    localparam logic [13:0] CSR_ERA       = 14'h006;
    localparam logic [13:0] CSR_BADV      = 14'h007;
    localparam logic [13:0] CSR_EENTRY    = 14'h00C;
    localparam logic [13:0] CSR_TCFG      = 14'h041;
    localparam logic [13:0] CSR_TVAL      = 14'h042;
    localparam logic [13:0] CSR_TICLR     = 14'h044;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

    // crmd: [1:0] PLV, [2] IE, [3] DA, [4] PG, [8:5] DATF/DATM
    logic [8:0]  crmd;
    logic [2:0]  prmd;
    logic [12:0] ecfg;
    logic [1:0]  is_sw;
    logic [7:0]  is_hw;
    logic        is_timer;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] era, badv;
    logic [25:0] eentry, tlbrentry;
    logic [31:0] estat;
    logic        timer_set, timer_clr;

    assign estat = {1'b0, esubcode, ecode, 3'b000, 1'b0, is_timer, 1'b0, is_hw, is_sw};

    function automatic logic wr(input logic [13:0] a);
        return csr_we && (csr_waddr == a);
    endfunction

    // Software write first, then flush updates override the fields they own.
    always_ff @(posedge clk) begin
        if (rst) begin
            crmd      <= 9'h008;
            prmd      <= '0;
            ecfg      <= '0;
            is_sw     <= '0;
            is_hw     <= '0;
            is_timer  <= 1'b0;
            ecode     <= '0;
            esubcode  <= '0;
            era       <= '0;
            badv      <= '0;
            eentry    <= '0;
            tlbrentry <= '0;
        end else begin
            is_hw <= hw_int_i;
            if (timer_set)      is_timer <= 1'b1;
            else if (timer_clr) is_timer <= 1'b0;
            if (wr(CSR_CRMD))      crmd      <= csr_wdata[8:0];
            if (wr(CSR_PRMD))      prmd      <= csr_wdata[2:0];
            if (wr(CSR_ECFG))      ecfg      <= csr_wdata[12:0];
            if (wr(CSR_ESTAT))     is_sw     <= csr_wdata[1:0];
            if (wr(CSR_ERA))       era       <= csr_wdata;
            if (wr(CSR_BADV))      badv      <= csr_wdata;
            if (wr(CSR_EENTRY))    eentry    <= csr_wdata[31:6];
            if (wr(CSR_TLBRENTRY)) tlbrentry <= csr_wdata[31:6];
            if (excp_flush) begin
                prmd     <= {crmd[2], crmd[1:0]};
                crmd[2:0] <= 3'b000;
                era      <= csr_era;
                ecode    <= csr_ecode;
                esubcode <= csr_esubcode;
                if (va_error) badv <= bad_va;
                if (excp_tlbrefill) begin
                    crmd[3] <= 1'b1;
                    crmd[4] <= 1'b0;
                end
            end else if (ertn_flush) begin
                crmd[2:0] <= prmd;
                if (ecode == 6'h3F) begin
                    crmd[3] <= 1'b0;
                    crmd[4] <= 1'b1;
                end
            end
        end
    end

    // Target is chosen from CSR values before this cycle's updates land.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= excp_flush | ertn_flush;
            if (excp_flush)
                redirect_pc <= excp_tlbrefill ? {tlbrentry, 6'b0} : {eentry, 6'b0};
            else if (ertn_flush)
                redirect_pc <= era;
        end
    end

`ifdef EXCP_CSR_TIMER_EN
    logic [31:0] tcfg, tval;

    assign timer_set = tcfg[0] && (tval == 32'd1) && !wr(CSR_TCFG);
    assign timer_clr = wr(CSR_TICLR) && csr_wdata[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tcfg <= '0;
            tval <= '0;
        end else if (wr(CSR_TCFG)) begin
            tcfg <= csr_wdata;
            tval <= {csr_wdata[31:2], 2'b00};
        end else if (tcfg[0]) begin
            if (tval != 32'd0)
                tval <= tval - 32'd1;
            else if (tcfg[1])
                tval <= {tcfg[31:2], 2'b00};
        end
    end
`else
    assign timer_set = 1'b0;
    assign timer_clr = 1'b0;
`endif

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_CRMD:      csr_rdata = {23'b0, crmd};
            CSR_PRMD:      csr_rdata = {29'b0, prmd};
            CSR_ECFG:      csr_rdata = {19'b0, ecfg};
            CSR_ESTAT:     csr_rdata = estat;
            CSR_ERA:       csr_rdata = era;
            CSR_BADV:      csr_rdata = badv;
            CSR_EENTRY:    csr_rdata = {eentry, 6'b0};
            CSR_TLBRENTRY: csr_rdata = {tlbrentry, 6'b0};
`ifdef EXCP_CSR_TIMER_EN
            CSR_TCFG:      csr_rdata = tcfg;
            CSR_TVAL:      csr_rdata = tval;
`endif
            default:       csr_rdata = '0;
        endcase
    end

    assign int_pending = crmd[2] & (|(estat[12:0] & ecfg));
    assign crmd_plv    = crmd[1:0];
    assign crmd_da     = crmd[3];
endmodule

// File: tb/tb_excp_csr_unit.sv
// Directed bench for excp_csr_unit; timer scenario depends on EXCP_CSR_TIMER_EN.
module tb_excp_csr_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        excp_flush = 1'b0, ertn_flush = 1'b0;
    logic [5:0]  csr_ecode = '0;
    logic [8:0]  csr_esubcode = '0;
    logic [31:0] csr_era = '0;
    logic        va_error = 1'b0;
    logic [31:0] bad_va = '0;
    logic        excp_tlbrefill = 1'b0;
    logic [7:0]  hw_int_i = '0;
    logic        csr_we = 1'b0;
    logic [13:0] csr_waddr = '0, csr_raddr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata, redirect_pc;
    logic        redirect_valid, int_pending, crmd_da;
    logic [1:0]  crmd_plv;

    int vecs = 0;
    int errs = 0;

    excp_csr_unit dut (
        .clk(clk), .rst(rst), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode), .csr_era(csr_era),
        .va_error(va_error), .bad_va(bad_va), .excp_tlbrefill(excp_tlbrefill),
        .hw_int_i(hw_int_i), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .int_pending(int_pending), .crmd_plv(crmd_plv),
        .crmd_da(crmd_da)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcsr(input logic [13:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        csr_raddr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd(14'h000, d);
            vecs++; if (d !== 32'h8) begin errs++; $display("FAIL reset_crmd cyc%0d got %h exp %h", i, d, 32'h8); end
            rd(14'h00C, d);
            vecs++; if (d !== 32'h0) begin errs++; $display("FAIL reset_eentry cyc%0d got %h exp 0", i, d); end
            vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL reset_redirect cyc%0d got %b exp 0", i, redirect_valid); end
            tick();
        end
        vecs++; if ({crmd_da, crmd_plv, int_pending} !== 4'b1000) begin errs++;
            $display("FAIL reset_outs got da=%b plv=%0d ip=%b exp da=1 plv=0 ip=0", crmd_da, crmd_plv, int_pending); end
        vecs++; if (redirect_pc !== 32'h0) begin errs++; $display("FAIL reset_rpc got %h exp 0", redirect_pc); end
    endtask

    task automatic test_exception();
        logic [31:0] d;
        wcsr(14'h00C, 32'h1C00_8000);
        wcsr(14'h000, 32'h7);
        vecs++; if (crmd_plv !== 2'd3) begin errs++; $display("FAIL exc_pre_plv got %0d exp 3", crmd_plv); end
        excp_flush = 1'b1; csr_ecode = 6'h0B; csr_era = 32'h1C00_1234; bad_va = 32'hDEAD_BEEF;
        tick();
        excp_flush = 1'b0;
        vecs++; if (redirect_valid !== 1'b1) begin errs++; $display("FAIL exc_rv got %b exp 1", redirect_valid); end
        vecs++; if (redirect_pc !== 32'h1C00_8000) begin errs++; $display("FAIL exc_rpc got %h exp 1c008000", redirect_pc); end
        rd(14'h006, d);
        vecs++; if (d !== 32'h1C00_1234) begin errs++; $display("FAIL exc_era got %h exp 1c001234", d); end
        rd(14'h001, d);
        vecs++; if (d !== 32'h7) begin errs++; $display("FAIL exc_prmd got %h exp 7", d); end
        rd(14'h000, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL exc_crmd got %h exp 0", d); end
        rd(14'h005, d);
        vecs++; if (d !== 32'h000B_0000) begin errs++; $display("FAIL exc_estat got %h exp 000b0000", d); end
        rd(14'h007, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL exc_badv_hold got %h exp 0", d); end
        tick();
        vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL exc_pulse got %b exp 0", redirect_valid); end
    endtask

    task automatic test_refill_ertn();
        logic [31:0] d;
        wcsr(14'h088, 32'h1C00_F03F);
        rd(14'h088, d);
        vecs++; if (d !== 32'h1C00_F000) begin errs++; $display("FAIL tlbr_mask got %h exp 1c00f000", d); end
        excp_flush = 1'b1; excp_tlbrefill = 1'b1; csr_ecode = 6'h3F; va_error = 1'b1;
        bad_va = 32'h4000_2000; csr_era = 32'h1C00_5678;
        tick();
        excp_flush = 1'b0; excp_tlbrefill = 1'b0; va_error = 1'b0;
        vecs++; if (redirect_pc !== 32'h1C00_F000) begin errs++; $display("FAIL refill_rpc got %h exp 1c00f000", redirect_pc); end
        rd(14'h007, d);
        vecs++; if (d !== 32'h4000_2000) begin errs++; $display("FAIL refill_badv got %h exp 40002000", d); end
        rd(14'h000, d);
        vecs++; if (d !== 32'h8) begin errs++; $display("FAIL refill_crmd got %h exp 8", d); end
        wcsr(14'h001, 32'hFF);
        rd(14'h001, d);
        vecs++; if (d !== 32'h7) begin errs++; $display("FAIL prmd_mask got %h exp 7", d); end
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        vecs++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_5678) begin errs++;
            $display("FAIL ertn_rpc got v=%b pc=%h exp v=1 pc=1c005678", redirect_valid, redirect_pc); end
        rd(14'h000, d);
        vecs++; if (d !== 32'h17) begin errs++; $display("FAIL ertn_crmd got %h exp 17", d); end
        vecs++; if (crmd_da !== 1'b0) begin errs++; $display("FAIL ertn_da got %b exp 0", crmd_da); end
    endtask

    task automatic test_both_flush();
        logic [31:0] d;
        excp_flush = 1'b1; ertn_flush = 1'b1; csr_ecode = 6'h0B; csr_era = 32'h1C00_AAAA;
        csr_we = 1'b1; csr_waddr = 14'h000; csr_wdata = 32'h3;
        tick();
        excp_flush = 1'b0; ertn_flush = 1'b0; csr_we = 1'b0;
        vecs++; if (redirect_pc !== 32'h1C00_8000) begin errs++; $display("FAIL both_rpc got %h exp 1c008000", redirect_pc); end
        rd(14'h000, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL both_crmd got %h exp 0", d); end
        rd(14'h001, d);
        vecs++; if (d !== 32'h7) begin errs++; $display("FAIL both_prmd got %h exp 7", d); end
        rd(14'h006, d);
        vecs++; if (d !== 32'h1C00_AAAA) begin errs++; $display("FAIL both_era got %h exp 1c00aaaa", d); end
        tick();
        vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL both_pulse got %b exp 0", redirect_valid); end
    endtask

    task automatic test_masks();
        logic [31:0] d;
        wcsr(14'h005, 32'hFFFF_FFFF);
        rd(14'h005, d);
        vecs++; if (d !== 32'h000B_0003) begin errs++; $display("FAIL estat_mask got %h exp 000b0003", d); end
        wcsr(14'h005, 32'h0);
        wcsr(14'h004, 32'hFFFF_FFFF);
        rd(14'h004, d);
        vecs++; if (d !== 32'h1FFF) begin errs++; $display("FAIL ecfg_mask got %h exp 1fff", d); end
        wcsr(14'h004, 32'h0);
        wcsr(14'h003, 32'hFFFF_FFFF);
        rd(14'h003, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL unimpl got %h exp 0", d); end
        csr_we = 1'b1; csr_waddr = 14'h006; csr_wdata = 32'h1234_5678; csr_raddr = 14'h006;
        #1;
        vecs++; if (csr_rdata !== 32'h1C00_AAAA) begin errs++; $display("FAIL no_bypass got %h exp 1c00aaaa", csr_rdata); end
        tick();
        csr_we = 1'b0;
        rd(14'h006, d);
        vecs++; if (d !== 32'h1234_5678) begin errs++; $display("FAIL era_wr got %h exp 12345678", d); end
    endtask

    task automatic test_hw_int();
        wcsr(14'h004, 32'h004);
        wcsr(14'h000, 32'h4);
        hw_int_i = 8'h01;
        #1;
        vecs++; if (int_pending !== 1'b0) begin errs++; $display("FAIL hwint_pre got %b exp 0", int_pending); end
        tick();
        vecs++; if (int_pending !== 1'b1) begin errs++; $display("FAIL hwint_set got %b exp 1", int_pending); end
        wcsr(14'h000, 32'h0);
        vecs++; if (int_pending !== 1'b0) begin errs++; $display("FAIL hwint_ie0 got %b exp 0", int_pending); end
        hw_int_i = 8'h00;
        wcsr(14'h004, 32'h0);
    endtask

`ifdef EXCP_CSR_TIMER_EN
    task automatic test_timer();
        logic [31:0] d;
        wcsr(14'h004, 32'h800);
        wcsr(14'h000, 32'h4);
        wcsr(14'h041, 32'h15);
        rd(14'h042, d);
        vecs++; if (d !== 32'd20) begin errs++; $display("FAIL tval_load got %0d exp 20", d); end
        for (int i = 0; i < 19; i++) tick();
        rd(14'h042, d);
        vecs++; if (d !== 32'd1 || int_pending !== 1'b0) begin errs++; $display("FAIL tval_19 got %0d ip=%b exp 1 ip=0", d, int_pending); end
        tick();
        rd(14'h042, d);
        vecs++; if (d !== 32'd0 || int_pending !== 1'b1) begin errs++; $display("FAIL tval_20 got %0d ip=%b exp 0 ip=1", d, int_pending); end
        tick(); tick();
        rd(14'h042, d);
        vecs++; if (d !== 32'd0) begin errs++; $display("FAIL tval_hold got %0d exp 0", d); end
        wcsr(14'h044, 32'h1);
        vecs++; if (int_pending !== 1'b0) begin errs++; $display("FAIL ticlr got %b exp 0", int_pending); end
        rd(14'h044, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL ticlr_rd got %h exp 0", d); end
        wcsr(14'h000, 32'h0);
        wcsr(14'h004, 32'h0);
    endtask
`else
    task automatic test_timer();
        logic [31:0] d;
        wcsr(14'h041, 32'h15);
        rd(14'h041, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL tcfg_off got %h exp 0", d); end
        for (int i = 0; i < 25; i++) tick();
        rd(14'h042, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL tval_off got %h exp 0", d); end
        rd(14'h005, d);
        vecs++; if (d[11] !== 1'b0) begin errs++; $display("FAIL is11_off got %b exp 0", d[11]); end
    endtask
`endif

    task automatic test_reset_flush();
        logic [31:0] d;
        excp_flush = 1'b1; rst = 1'b1; csr_era = 32'h1111_2222;
        tick();
        excp_flush = 1'b0; rst = 1'b0;
        vecs++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errs++;
            $display("FAIL rstflush_rv got v=%b pc=%h exp v=0 pc=0", redirect_valid, redirect_pc); end
        rd(14'h006, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL rstflush_era got %h exp 0", d); end
        tick();
        vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL rstflush_pulse got %b exp 0", redirect_valid); end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_refill_ertn();
        test_both_flush();
        test_masks();
        test_hw_int();
        test_timer();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/excp_csr_unit.md
EXCP_CSR_UNIT -- requirements
Module: excp_csr_unit

Interface
REQ-001 Clock clk and reset rst (synchronous, active-high) SHALL be the only clock and reset.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
 clk  in  1  clock
 rst  in  1  sync active-high reset
 excp_flush  in  1  exception committed this cycle
 ertn_flush  in  1  ertn committed this cycle
 csr_ecode  in  6  exception code
 csr_esubcode  in  9  exception subcode
 csr_era  in  32  faulting PC
 va_error  in  1  bad_va valid
 bad_va  in  32  faulting virtual address
 excp_tlbrefill  in  1  exception is TLB refill
 hw_int_i  in  8  hardware interrupt lines
 csr_we  in  1  software CSR write strobe
 csr_waddr  in  14  write address
 csr_wdata  in  32  write data
 csr_raddr  in  14  read address
 csr_rdata  out  32  combinational read data
 redirect_valid  out  1  fetch redirect pulse
 redirect_pc  out  32  redirect target
 int_pending  out  1  unmasked interrupt pending
 crmd_plv  out  2  current privilege level
 crmd_da  out  1  direct-address mode

Function
REQ-003 Implemented CSRs: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, TCFG 0x41, TVAL 0x42, TICLR 0x44, TLBRENTRY 0x88; all other addresses SHALL read 0 and ignore writes.
REQ-004 On excp_flush: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ERA<=csr_era, ESTAT[21:16]<=csr_ecode, ESTAT[30:22]<=csr_esubcode.
REQ-005 On excp_flush with va_error=1, BADV<=bad_va; with va_error=0, BADV SHALL hold.
REQ-006 On excp_flush with excp_tlbrefill=1: CRMD.DA<=1, CRMD.PG<=0.
REQ-007 On ertn_flush: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; if ESTAT.Ecode==0x3F, CRMD.DA<=0, CRMD.PG<=1.
REQ-008 redirect_valid SHALL pulse exactly one cycle, the cycle after excp_flush or ertn_flush.
REQ-009 redirect_pc SHALL be TLBRENTRY (refill), EENTRY (other exception) or ERA (ertn), sampled from pre-update CSR values in the flush cycle.
REQ-010 excp_flush and ertn_flush together: exception SHALL win; ertn ignored.
REQ-011 csr_we in the same cycle as a flush: flush-modified fields SHALL take flush values; other fields take the write.
REQ-012 Write masks: CRMD[8:0], PRMD[2:0], ECFG[12:0], ESTAT[1:0] only, ERA full, BADV full, EENTRY[31:6], TLBRENTRY[31:6], TCFG[31:0]; read-only bits SHALL be unaffected.
REQ-013 ESTAT.IS[9:2] SHALL register hw_int_i every cycle (1-cycle latency).
REQ-014 int_pending = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.
REQ-015 csr_rdata SHALL reflect register state only (no same-cycle write bypass).

Reset
REQ-016 On rst: CRMD=0x0000_0008 (DA=1, PLV=0, IE=0), all other CSRs=0, redirect_valid=0, redirect_pc=0; int_pending, crmd_plv=0, crmd_da=1 follow.
REQ-017 rst asserted in a flush cycle SHALL override; no redirect pulse follows.

Configuration
REQ-018 Macro EXCP_CSR_TIMER_EN defined: TCFG write loads TVAL={TCFG.InitVal,2'b00}; TVAL decrements by 1 per cycle while TCFG.En=1 and TVAL!=0.
REQ-019 With timer: TVAL transition 1->0 sets ESTAT.IS[11]; Periodic=1 reloads TVAL next cycle, Periodic=0 holds TVAL at 0; TICLR write with wdata[0]=1 clears IS[11], TICLR reads 0; TICLR clear and timer set same cycle -> set wins.
REQ-020 Macro undefined: TCFG/TVAL/TICLR SHALL read 0, ignore writes, IS[11] constant 0.

Verification
REQ-021 Reset -> read CRMD=0x8, EENTRY=0, redirect_valid=0 for 10 cycles.
REQ-022 EENTRY=0x1C00_8000, CRMD=0x7 (PLV3, IE1); excp_flush, ecode 0x0B, era 0x1C00_1234 -> next cycle redirect_pc=0x1C00_8000 single pulse; ERA=0x1C00_1234, PRMD=0x7, CRMD.PLV=0, IE=0.
REQ-023 TLBRENTRY=0x1C00_F000; excp_flush, excp_tlbrefill=1, ecode 0x3F, bad_va 0x4000_2000, va_error=1 -> redirect_pc=0x1C00_F000, BADV=0x4000_2000, CRMD.DA=1; then ertn_flush -> redirect_pc=ERA, DA=0, PG=1.
REQ-024 excp_flush and ertn_flush same cycle, csr_we CRMD=0x3 -> exception path taken, CRMD.PLV=0, IE=0.
REQ-025 ECFG.LIE=0x800, CRMD.IE=1, TCFG=0x0000_0015 (InitVal=5, Periodic=0, En=1) -> TVAL reaches 0 after 20 cycles, IS[11]=1, int_pending=1; TICLR=1 -> int_pending=0 next cycle (EXCP_CSR_TIMER_EN only).
REQ-026 hw_int_i=0x01, ECFG.LIE=0x004, CRMD.IE=1 -> int_pending=1 one cycle after hw_int_i asserts; IE=0 -> int_pending=0.
